// File: rtl/object_centroid_pkg.sv
// Shared definitions for the object tracking pipeline (centroid and overlay stages).
package object_centroid_pkg;

    localparam int unsigned DISP_WIDTH_DEF = 11;
    localparam int unsigned CNT_WIDTH_DEF  = 22;
    localparam int unsigned SUM_WIDTH_DEF  = DISP_WIDTH_DEF + CNT_WIDTH_DEF;
    localparam int unsigned MIN_PIXELS_DEF = 64;

    typedef enum logic [1:0] {
        ST_ACCUM  = 2'd0,
        ST_DIVIDE = 2'd1,
        ST_UPDATE = 2'd2
    } track_state_e;

endpackage

// File: rtl/object_centroid_serial_divider.sv
// Unsigned restoring divider, one quotient bit per cycle; the start cycle already
// resolves the first bit so a DVD_W-bit division occupies exactly DVD_W cycles.
module serial_divider
    import object_centroid_pkg::*;
#(
    parameter int unsigned DVD_W = SUM_WIDTH_DEF,
    parameter int unsigned DVS_W = CNT_WIDTH_DEF,
    parameter int unsigned Q_W   = DISP_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             aresetn,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic             done,
    output logic [Q_W-1:0]   quotient
);

    localparam int unsigned STEP_W = $clog2(DVD_W + 1);
    localparam logic [STEP_W-1:0] FIRST_LEFT = STEP_W'(DVD_W - 1);
    localparam logic [STEP_W-1:0] STEP_ONE   = STEP_W'(1);

    logic [DVS_W-1:0]  rem_q, rem_d;
    logic [DVD_W-1:0]  quo_q, quo_d;
    logic [DVS_W-1:0]  dvs_q, dvs_d;
    logic [STEP_W-1:0] left_q, left_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [DVS_W-1:0]  src_rem;
    logic [DVD_W-1:0]  src_quo;
    logic [DVS_W-1:0]  src_dvs;
    logic [DVS_W:0]    shifted;
    logic              take;

    always_comb begin
        src_rem = start ? '0 : rem_q;
        src_quo = start ? dividend : quo_q;
        src_dvs = start ? divisor : dvs_q;
        shifted = {src_rem, src_quo[DVD_W-1]};
        take    = (shifted >= {1'b0, src_dvs});

        rem_d  = rem_q;
        quo_d  = quo_q;
        dvs_d  = dvs_q;
        left_d = left_q;
        busy_d = busy_q;
        done_d = 1'b0;

        if (start || busy_q) begin
            rem_d = take ? DVS_W'(shifted - {1'b0, src_dvs}) : shifted[DVS_W-1:0];
            quo_d = {src_quo[DVD_W-2:0], take};
            if (start) begin
                dvs_d  = divisor;
                left_d = FIRST_LEFT;
                busy_d = 1'b1;
            end else begin
                left_d = left_q - STEP_ONE;
                if (left_q == STEP_ONE) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            left_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvs_q  <= dvs_d;
            left_q <= left_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign done     = done_q;
    assign quotient = quo_q[Q_W-1:0];

endmodule

// File: rtl/object_centroid.sv
// Per-frame object centroid: accumulates masked pixel coordinates, then divides the
// sums by the pixel count at end of frame and registers the new centre.
module object_centroid
    import object_centroid_pkg::*;
#(
    parameter int unsigned DISP_WIDTH = DISP_WIDTH_DEF,
    parameter int unsigned CNT_WIDTH  = CNT_WIDTH_DEF,
    parameter int unsigned SUM_WIDTH  = SUM_WIDTH_DEF,
    parameter int unsigned MIN_PIXELS = MIN_PIXELS_DEF
) (
    input  logic                  clk,
    input  logic                  aresetn,
    input  logic                  enable,
    input  logic                  pix_valid,
    input  logic                  is_object,
    input  logic                  eof,
    input  logic [DISP_WIDTH-1:0] x_pos,
    input  logic [DISP_WIDTH-1:0] y_pos,
    output logic [DISP_WIDTH-1:0] x_obj,
    output logic [DISP_WIDTH-1:0] y_obj,
    output logic                  obj_found,
    output logic                  obj_update,
    output logic                  busy
);

    if (MIN_PIXELS == 0) begin : g_bad_min_pixels
        $error("object_centroid: MIN_PIXELS must be at least 1");
    end

    localparam logic [CNT_WIDTH-1:0] MIN_CNT = CNT_WIDTH'(MIN_PIXELS);

    track_state_e          state_q, state_d;
    logic [SUM_WIDTH-1:0]  sum_x_q, sum_x_d;
    logic [SUM_WIDTH-1:0]  sum_y_q, sum_y_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  ovf_q, ovf_d;
    logic [DISP_WIDTH-1:0] x_obj_q, x_obj_d;
    logic [DISP_WIDTH-1:0] y_obj_q, y_obj_d;
    logic                  found_q, found_d;
    logic                  found_next_q, found_next_d;
    logic                  upd_q, upd_d;
    logic [7:0]            drop_cnt_q, drop_cnt_d;

    logic                  acc_hit;
    logic                  eof_en;
    logic [SUM_WIDTH:0]    sx_ext;
    logic [SUM_WIDTH:0]    sy_ext;
    logic                  div_start;
    logic                  div_done_x, div_done_y;
    logic [DISP_WIDTH-1:0] quo_x, quo_y;

    // Accumulators run in every FSM state; eof snapshots into the dividers and clears.
    always_comb begin
        acc_hit = enable && pix_valid && is_object && !eof;
        eof_en  = enable && eof;
        sx_ext  = {1'b0, sum_x_q} + (SUM_WIDTH+1)'(x_pos);
        sy_ext  = {1'b0, sum_y_q} + (SUM_WIDTH+1)'(y_pos);

        sum_x_d = sum_x_q;
        sum_y_d = sum_y_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;

        if (eof_en) begin
            sum_x_d = '0;
            sum_y_d = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else if (acc_hit) begin
            if (sx_ext[SUM_WIDTH]) begin
                sum_x_d = '1;
                ovf_d   = 1'b1;
            end else begin
                sum_x_d = sx_ext[SUM_WIDTH-1:0];
            end
            if (sy_ext[SUM_WIDTH]) begin
                sum_y_d = '1;
                ovf_d   = 1'b1;
            end else begin
                sum_y_d = sy_ext[SUM_WIDTH-1:0];
            end
            if (cnt_q == '1) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        div_start    = 1'b0;
        x_obj_d      = x_obj_q;
        y_obj_d      = y_obj_q;
        found_d      = found_q;
        found_next_d = found_next_q;
        upd_d        = 1'b0;
        drop_cnt_d   = drop_cnt_q;

        case (state_q)
            ST_ACCUM: begin
                if (eof_en) begin
                    if ((cnt_q < MIN_CNT) || ovf_q) begin
                        found_next_d = 1'b0;
                        state_d      = ST_UPDATE;
                    end else begin
                        found_next_d = 1'b1;
                        div_start    = 1'b1;
                        state_d      = ST_DIVIDE;
                    end
                end
            end
            ST_DIVIDE: begin
                if (eof_en && (drop_cnt_q != '1)) begin
                    drop_cnt_d = drop_cnt_q + 8'd1;
                end
                if (div_done_x && div_done_y) begin
                    state_d = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                if (eof_en && (drop_cnt_q != '1)) begin
                    drop_cnt_d = drop_cnt_q + 8'd1;
                end
                upd_d   = 1'b1;
                found_d = found_next_q;
                if (found_next_q) begin
                    x_obj_d = quo_x;
                    y_obj_d = quo_y;
                end
                state_d = ST_ACCUM;
            end
            default: state_d = ST_ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= ST_ACCUM;
            sum_x_q      <= '0;
            sum_y_q      <= '0;
            cnt_q        <= '0;
            ovf_q        <= 1'b0;
            x_obj_q      <= '0;
            y_obj_q      <= '0;
            found_q      <= 1'b0;
            found_next_q <= 1'b0;
            upd_q        <= 1'b0;
            drop_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            sum_x_q      <= sum_x_d;
            sum_y_q      <= sum_y_d;
            cnt_q        <= cnt_d;
            ovf_q        <= ovf_d;
            x_obj_q      <= x_obj_d;
            y_obj_q      <= y_obj_d;
            found_q      <= found_d;
            found_next_q <= found_next_d;
            upd_q        <= upd_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    serial_divider #(
        .DVD_W(SUM_WIDTH),
        .DVS_W(CNT_WIDTH),
        .Q_W  (DISP_WIDTH)
    ) u_div_x (
        .clk     (clk),
        .aresetn (aresetn),
        .start   (div_start),
        .dividend(sum_x_q),
        .divisor (cnt_q),
        .done    (div_done_x),
        .quotient(quo_x)
    );

    serial_divider #(
        .DVD_W(SUM_WIDTH),
        .DVS_W(CNT_WIDTH),
        .Q_W  (DISP_WIDTH)
    ) u_div_y (
        .clk     (clk),
        .aresetn (aresetn),
        .start   (div_start),
        .dividend(sum_y_q),
        .divisor (cnt_q),
        .done    (div_done_y),
        .quotient(quo_y)
    );

    assign x_obj      = x_obj_q;
    assign y_obj      = y_obj_q;
    assign obj_found  = found_q;
    assign obj_update = upd_q;
    assign busy       = (state_q == ST_DIVIDE);

endmodule

// File: tb/tb_object_centroid.sv
// Directed and randomized frames for object_centroid, checked against a per-frame
// sum/count reference model.
module tb_object_centroid;

    logic        clk = 1'b0;
    logic        aresetn;
    logic        enable = 1'b0;
    logic        pix_valid = 1'b0;
    logic        is_object = 1'b0;
    logic        eof = 1'b0;
    logic [10:0] x_pos = '0;
    logic [10:0] y_pos = '0;
    logic [10:0] x_obj, y_obj;
    logic        obj_found, obj_update, busy;

    int checks = 0;
    int failures = 0;

    longint m_sx = 0, m_sy = 0, m_cnt = 0;
    longint s_sx = 0, s_sy = 0, s_cnt = 0;
    longint e_x = 0, e_y = 0;
    logic   e_found = 1'b0;

    always #5 clk = ~clk;

    object_centroid #(
        .DISP_WIDTH(11),
        .CNT_WIDTH (22),
        .SUM_WIDTH (33),
        .MIN_PIXELS(64)
    ) dut (
        .clk       (clk),
        .aresetn   (aresetn),
        .enable    (enable),
        .pix_valid (pix_valid),
        .is_object (is_object),
        .eof       (eof),
        .x_pos     (x_pos),
        .y_pos     (y_pos),
        .x_obj     (x_obj),
        .y_obj     (y_obj),
        .obj_found (obj_found),
        .obj_update(obj_update),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One pixel-clock cycle of stimulus; the model follows the accumulation rules.
    task automatic cyc(input logic v, input logic obj, input int x, input int y, input logic e);
        pix_valid = v;
        is_object = obj;
        x_pos     = 11'(x);
        y_pos     = 11'(y);
        eof       = e;
        if (enable && e) begin
            s_sx = m_sx; s_sy = m_sy; s_cnt = m_cnt;
            m_sx = 0; m_sy = 0; m_cnt = 0;
        end else if (enable && v && obj) begin
            m_sx += x; m_sy += y; m_cnt += 1;
        end
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
        is_object = 1'b0;
        eof       = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic noise();
        int rx, ry;
        rx = int'($urandom_range(0, 2047));
        ry = int'($urandom_range(0, 2047));
        if ($urandom_range(0, 1) == 1) cyc(1'b1, 1'b0, rx, ry, 1'b0);
        else                           cyc(1'b0, 1'b1, rx, ry, 1'b0);
    endtask

    task automatic rand_frame(input int n);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) noise();
            cyc(1'b1, 1'b1, int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)), 1'b0);
        end
    endtask

    task automatic finish_frame(input string tag);
        int lat;
        cyc(1'b0, 1'b0, 0, 0, 1'b1);
        e_found = (s_cnt >= 64);
        if (e_found) begin
            e_x = s_sx / s_cnt;
            e_y = s_sy / s_cnt;
        end
        chk({tag, "_busy_start"}, busy, e_found);
        lat = 1;
        while (obj_update !== 1'b1 && lat < 100) begin
            cyc(1'b0, 1'b0, 0, 0, 1'b0);
            lat++;
        end
        chk({tag, "_latency"}, lat, e_found ? 35 : 2);
        chk({tag, "_found"}, obj_found, e_found);
        chk({tag, "_x"}, x_obj, e_x);
        chk({tag, "_y"}, y_obj, e_y);
        idle(1);
        chk({tag, "_pulse_end"}, obj_update, 1'b0);
        chk({tag, "_busy_end"}, busy, 1'b0);
    endtask

    initial begin
        int     nupd;
        int     first;
        longint ux, uy, ex1, ey1;

        aresetn = 1'b1;
        #1 aresetn = 1'b0;
        #2;
        chk("rst_x", x_obj, 0);
        chk("rst_y", y_obj, 0);
        chk("rst_found", obj_found, 0);
        chk("rst_update", obj_update, 0);
        chk("rst_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1 aresetn = 1'b1;
        enable = 1'b1;
        idle(3);

        // 10x10 block with unqualified noise pixels mixed in
        for (int y = 50; y <= 59; y++) begin
            for (int x = 100; x <= 109; x++) begin
                if ($urandom_range(0, 2) == 0) noise();
                cyc(1'b1, 1'b1, x, y, 1'b0);
            end
        end
        finish_frame("block");
        chk("block_x_const", x_obj, 104);
        chk("block_y_const", y_obj, 54);

        repeat (10) cyc(1'b1, 1'b1, 300, 200, 1'b0);
        finish_frame("below");
        chk("below_x_hold", x_obj, 104);
        chk("below_y_hold", y_obj, 54);

        repeat (2) begin
            rand_frame(64 + int'($urandom_range(0, 200)));
            finish_frame("rand");
        end

        // eof arriving while the divider is busy
        rand_frame(100);
        cyc(1'b0, 1'b0, 0, 0, 1'b1);
        ex1 = s_sx / s_cnt;
        ey1 = s_sy / s_cnt;
        nupd = 0; first = 0; ux = 0; uy = 0;
        for (int i = 1; i <= 80; i++) begin
            if (i == 1) chk("drop_busy_start", busy, 1'b1);
            if (obj_update === 1'b1) begin
                nupd++;
                if (first == 0) begin
                    first = i; ux = longint'(x_obj); uy = longint'(y_obj);
                end
            end
            if (i <= 9)       cyc(1'b1, 1'b1, (i - 1) % 8, (i - 1) / 8, 1'b0);
            else if (i == 10) cyc(1'b0, 1'b0, 0, 0, 1'b1);
            else              cyc(1'b0, 1'b0, 0, 0, 1'b0);
        end
        chk("drop_updates", nupd, 1);
        chk("drop_latency", first, 35);
        chk("drop_x", ux, ex1);
        chk("drop_y", uy, ey1);
        chk("drop_counter", dut.drop_cnt_q, 1);
        chk("drop_busy_end", busy, 1'b0);
        e_x = ex1; e_y = ey1;
        rand_frame(80);
        finish_frame("after_drop");

        repeat (63) cyc(1'b1, 1'b1, 0, 0, 1'b0);
        cyc(1'b1, 1'b1, 2047, 2047, 1'b0);
        finish_frame("asym");
        chk("asym_x_const", x_obj, 31);
        chk("asym_y_const", y_obj, 31);

        // reset at divide cycle 10, with some pixels already accumulated
        rand_frame(90);
        cyc(1'b0, 1'b0, 0, 0, 1'b1);
        repeat (9) cyc(1'b1, 1'b1, 5, 5, 1'b0);
        #2 aresetn = 1'b0;
        #1;
        chk("midrst_x", x_obj, 0);
        chk("midrst_y", y_obj, 0);
        chk("midrst_found", obj_found, 0);
        chk("midrst_update", obj_update, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_count", dut.cnt_q, 0);
        m_sx = 0; m_sy = 0; m_cnt = 0; e_x = 0; e_y = 0;
        @(posedge clk);
        #3 aresetn = 1'b1;
        @(posedge clk);
        #1;
        nupd = 0;
        repeat (40) begin
            if (obj_update === 1'b1) nupd++;
            idle(1);
        end
        chk("midrst_no_update", nupd, 0);

        // 640x480 frame decimated symmetrically: every 8th column/row plus mirror images
        for (int yi = 0; yi < 120; yi++) begin
            for (int xi = 0; xi < 160; xi++) begin
                cyc(1'b1, 1'b1,
                    (xi < 80) ? xi * 8 : 639 - (xi - 80) * 8,
                    (yi < 60) ? yi * 8 : 479 - (yi - 60) * 8, 1'b0);
            end
        end
        finish_frame("frame640");
        chk("frame640_x_const", x_obj, 319);
        chk("frame640_y_const", y_obj, 239);

        // disabled tracking: accumulators and outputs frozen, eof ignored
        repeat (20) cyc(1'b1, 1'b1, 400, 300, 1'b0);
        enable = 1'b0;
        rand_frame(100);
        cyc(1'b0, 1'b0, 0, 0, 1'b1);
        nupd = 0;
        repeat (50) begin
            if (obj_update === 1'b1) nupd++;
            idle(1);
        end
        chk("dis_no_update", nupd, 0);
        chk("dis_count", dut.cnt_q, m_cnt);
        chk("dis_sum_x", dut.sum_x_q, m_sx);
        chk("dis_x_hold", x_obj, e_x);
        enable = 1'b1;
        rand_frame(70);
        finish_frame("reenable");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
